// File: rtl/int_request_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// int_request_conditioner_pkg
// Shared constants for the external interrupt conditioning path in front of
// coprocessor 0. CP0 and the conditioner both size their interrupt vectors
// from CP0_NUM_EXT_INT so the two can never disagree on the line count.
// No ports; constants only.
// -----------------------------------------------------------------------------
package int_request_conditioner_pkg;

   // Number of external interrupt lines feeding CP0 INT1..INT7.
   localparam int CP0_NUM_EXT_INT = 7;

   // Default number of consecutive stable cycles before a filtered level flips.
   localparam int INT_FILTER_CYCLES_DEFAULT = 4;

   // Default synchroniser depth for the raw asynchronous lines.
   localparam int INT_SYNC_STAGES_DEFAULT = 2;

endpackage : int_request_conditioner_pkg

// File: rtl/int_request_conditioner_line_filter.sv
// -----------------------------------------------------------------------------
// int_line_filter
// One interrupt line: brings the raw asynchronous input into the clock domain
// through a flop chain, then debounces it so the filtered level only changes
// after the synchronised value has disagreed with it for FILTER_CYCLES
// consecutive cycles. A one-cycle delayed copy of the filtered level is also
// kept so the parent can detect rising edges.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-high reset, clears every flop
//   irq_i          raw asynchronous interrupt line
//   filtered_o     debounced level
//   filteredDly_o  debounced level delayed by one cycle
// -----------------------------------------------------------------------------
module int_line_filter
   import int_request_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES   = INT_SYNC_STAGES_DEFAULT,
   parameter int FILTER_CYCLES = INT_FILTER_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic irq_i,
   output logic filtered_o,
   output logic filteredDly_o
);

   localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       filterCnt_q;
   logic                   filtered_q;
   logic                   filteredDly_q;
   logic                   syncOut;

   assign syncOut = sync_q[SYNC_STAGES-1];

   // Synchroniser chain: the raw line enters at bit 0 and is only used once
   // it has passed through every stage, giving metastability time to settle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      end
   end

   // Debounce counter: counts consecutive cycles the synchronised value
   // disagrees with the filtered level. A single agreeing cycle restarts the
   // count, so only a disagreement held for the full window flips the level.
   // The delayed copy feeds the parent's rising-edge detector.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         filterCnt_q   <= '0;
         filtered_q    <= 1'b0;
         filteredDly_q <= 1'b0;
      end else begin
         filteredDly_q <= filtered_q;
         if (syncOut == filtered_q) begin
            filterCnt_q <= '0;
         end else if (filterCnt_q == CNT_LAST) begin
            filtered_q  <= syncOut;
            filterCnt_q <= '0;
         end else begin
            filterCnt_q <= filterCnt_q + CNT_W'(1);
         end
      end
   end

   assign filtered_o    = filtered_q;
   assign filteredDly_o = filteredDly_q;

endmodule : int_line_filter

// File: rtl/int_request_conditioner.sv
// -----------------------------------------------------------------------------
// int_request_conditioner
// Conditions raw external interrupt lines for CP0 INT1..INT7. Each line is
// synchronised and debounced, turned into a level or rising-edge request, and
// held pending until CP0 acknowledges it. Lines are fully independent; CP0
// does all prioritisation.
//
// Ports:
//   CLK        clock, all state on the rising edge
//   RESET      asynchronous active-high reset
//   IRQ_IN     raw asynchronous interrupt lines
//   ENABLE     per-line enable (quasi-static)
//   EDGE_MODE  1 = rising-edge triggered, 0 = level triggered
//   ACK        one-hot acknowledge from CP0, valid for one cycle
//   OVR_CLR    clears the matching OVERRUN bits
//   INT_OUT    registered pending requests to CP0
//   OVERRUN    sticky: an edge arrived while that line was already pending
//   FILTERED   debounced line levels for status reads
// -----------------------------------------------------------------------------
module int_request_conditioner
   import int_request_conditioner_pkg::*;
#(
   parameter int NUM_LINES     = CP0_NUM_EXT_INT,
   parameter int SYNC_STAGES   = INT_SYNC_STAGES_DEFAULT,
   parameter int FILTER_CYCLES = INT_FILTER_CYCLES_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NUM_LINES-1:0] IRQ_IN,
   input  logic [NUM_LINES-1:0] ENABLE,
   input  logic [NUM_LINES-1:0] EDGE_MODE,
   input  logic [NUM_LINES-1:0] ACK,
   input  logic [NUM_LINES-1:0] OVR_CLR,
   output logic [NUM_LINES-1:0] INT_OUT,
   output logic [NUM_LINES-1:0] OVERRUN,
   output logic [NUM_LINES-1:0] FILTERED
);

   logic [NUM_LINES-1:0] filtLevel;
   logic [NUM_LINES-1:0] filtLevelDly;
   logic [NUM_LINES-1:0] rise;
   logic [NUM_LINES-1:0] setReq;
   logic [NUM_LINES-1:0] pending_d, pending_q;
   logic [NUM_LINES-1:0] overrun_d, overrun_q;

   // One synchroniser/debounce slice per line. The filter runs regardless of
   // ENABLE so FILTERED always reflects the real line state.
   for (genvar i = 0; i < NUM_LINES; i++) begin : gLine
      int_line_filter #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES)
      ) uFilter (
         .clk_i         (CLK),
         .rst_i         (RESET),
         .irq_i         (IRQ_IN[i]),
         .filtered_o    (filtLevel[i]),
         .filteredDly_o (filtLevelDly[i])
      );
   end

   // Request generation and pending/overrun next state. Disable beats
   // everything, a new request beats a simultaneous ACK so no edge is lost,
   // and a new overrun beats a simultaneous clear. An edge that coincides
   // with ACK is a fresh request rather than an overrun.
   always_comb begin
      rise      = filtLevel & ~filtLevelDly;
      setReq    = ENABLE & ((EDGE_MODE & rise) | (~EDGE_MODE & filtLevel));
      pending_d = ENABLE & (setReq | (pending_q & ~ACK));
      overrun_d = (EDGE_MODE & ENABLE & rise & pending_q & ~ACK)
                | (overrun_q & ~OVR_CLR);
   end

   // Pending and overrun registers; reset discards every in-flight request.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign INT_OUT  = pending_q;
   assign OVERRUN  = overrun_q;
   assign FILTERED = filtLevel;

endmodule : int_request_conditioner

// File: tb/tb_int_request_conditioner.sv
module tb_int_request_conditioner;
   import int_request_conditioner_pkg::*;

   localparam int N  = CP0_NUM_EXT_INT;
   localparam int SS = 2;
   localparam int FC = INT_FILTER_CYCLES_DEFAULT;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [N-1:0] IRQ_IN, ENABLE, EDGE_MODE, ACK, OVR_CLR;
   logic [N-1:0] INT_OUT, OVERRUN, FILTERED;

   int_request_conditioner #(
      .NUM_LINES     (N),
      .SYNC_STAGES   (SS),
      .FILTER_CYCLES (FC)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .IRQ_IN    (IRQ_IN),
      .ENABLE    (ENABLE),
      .EDGE_MODE (EDGE_MODE),
      .ACK       (ACK),
      .OVR_CLR   (OVR_CLR),
      .INT_OUT   (INT_OUT),
      .OVERRUN   (OVERRUN),
      .FILTERED  (FILTERED)
   );

   // 10 ns clock period
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [N-1:0] intOut;
      logic [N-1:0] overrun;
      logic [N-1:0] filtered;
   } expect_t;

   expect_t      scoreQ[$];
   int           checkCount = 0;
   int           passCount  = 0;

   // Current stimulus values, applied on the next cycle
   logic [N-1:0] irqV, enV, emV, ackV, clrV;

   // Behavioural model state
   logic [N-1:0] irqHist[$];
   logic [N-1:0] mF, mFq, mInt, mOvr;
   int           mRun[N];

   function automatic void compareField(string name, logic [N-1:0] act, logic [N-1:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s at %0t: got %b, required %b", name, $time, act, exp);
   endfunction

   function automatic void compareInt(string name, int act, int exp);
      checkCount++;
      if (act == exp) passCount++;
      else $display("[TB] FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
   endfunction

   function automatic void modelReset();
      irqHist.delete();
      mF = '0; mFq = '0; mInt = '0; mOvr = '0;
      for (int i = 0; i < N; i++) mRun[i] = 0;
   endfunction

   // One clock edge of the reference: every register updates from the
   // values that were visible during the preceding cycle.
   function automatic void modelStep(logic [N-1:0] irq, logic [N-1:0] en, logic [N-1:0] em,
                                     logic [N-1:0] ack, logic [N-1:0] clr);
      logic [N-1:0] s, nF, nInt, nOvr;
      logic         rise, setv;
      s = (irqHist.size() >= SS) ? irqHist[SS-1] : '0;
      for (int i = 0; i < N; i++) begin
         nF[i] = mF[i];
         if (s[i] != mF[i]) begin
            mRun[i]++;
            if (mRun[i] == FC) begin
               nF[i]   = s[i];
               mRun[i] = 0;
            end
         end else begin
            mRun[i] = 0;
         end
         rise = mF[i] && !mFq[i];
         setv = en[i] && (em[i] ? rise : mF[i]);
         if (!en[i])      nInt[i] = 1'b0;
         else if (setv)   nInt[i] = 1'b1;
         else if (ack[i]) nInt[i] = 1'b0;
         else             nInt[i] = mInt[i];
         if (em[i] && en[i] && rise && mInt[i] && !ack[i]) nOvr[i] = 1'b1;
         else if (clr[i])                                  nOvr[i] = 1'b0;
         else                                              nOvr[i] = mOvr[i];
      end
      mFq  = mF;
      mF   = nF;
      mInt = nInt;
      mOvr = nOvr;
      irqHist.push_front(irq);
      if (irqHist.size() > SS) void'(irqHist.pop_back());
      scoreQ.push_back('{intOut: mInt, overrun: mOvr, filtered: mF});
   endfunction

   task automatic checkOutput(expect_t e);
      compareField("INT_OUT",  INT_OUT,  e.intOut);
      compareField("OVERRUN",  OVERRUN,  e.overrun);
      compareField("FILTERED", FILTERED, e.filtered);
   endtask

   // Monitor: compares the DUT against the oldest expectation, mid-cycle
   always @(negedge CLK) begin
      if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
   end

   // Drives one cycle of stimulus; called at posedge+1, returns at posedge+1.
   // ACK and OVR_CLR are single-cycle pulses.
   task automatic applyStimulus();
      IRQ_IN    = irqV;
      ENABLE    = enV;
      EDGE_MODE = emV;
      ACK       = ackV;
      OVR_CLR   = clrV;
      @(posedge CLK);
      modelStep(irqV, enV, emV, ackV, clrV);
      #1;
      ackV = '0;
      clrV = '0;
   endtask

   task automatic tick(int n);
      for (int k = 0; k < n; k++) applyStimulus();
   endtask

   // Ticks until INT_OUT[line] rises, bounded, and checks the edge count
   task automatic measureLatency(string name, int line, int expEdges);
      int count;
      count = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus();
         count++;
         if (INT_OUT[line]) break;
      end
      if (!INT_OUT[line]) count = -1;
      compareInt(name, count, expEdges);
   endtask

   // Asynchronous reset away from any edge; outputs must clear immediately
   task automatic doReset();
      @(negedge CLK);
      #1;
      RESET = 1'b1;
      #1;
      compareField("reset INT_OUT",  INT_OUT,  '0);
      compareField("reset OVERRUN",  OVERRUN,  '0);
      compareField("reset FILTERED", FILTERED, '0);
      modelReset();
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   initial begin
      logic [N-1:0] flip;
      int           drainWait;
      RESET = 1'b1;
      irqV = '0; enV = '0; emV = '0; ackV = '0; clrV = '0;
      IRQ_IN = '0; ENABLE = '0; EDGE_MODE = '0; ACK = '0; OVR_CLR = '0;
      modelReset();
      @(posedge CLK);
      #1;
      RESET = 1'b0;

      // Quiet lines with everything enabled: nothing may appear
      enV = '1;
      tick(20);
      compareField("idle INT_OUT", INT_OUT, '0);

      // Line 0 edge mode: 7-edge latency, ACK clears and it stays clear
      emV = 7'b0001010 | 7'b0000001;
      irqV[0] = 1'b1;
      measureLatency("edge latency line0", 0, SS + FC + 1);
      ackV[0] = 1'b1;
      tick(1);
      compareInt("line0 after ACK", int'(INT_OUT[0]), 0);
      tick(10);
      compareInt("line0 stays clear", int'(INT_OUT[0]), 0);

      // Line 2 level mode: ACK while high does not clear
      irqV[2] = 1'b1;
      measureLatency("level latency line2", 2, SS + FC + 1);
      ackV[2] = 1'b1;
      tick(3);
      compareInt("line2 held by level", int'(INT_OUT[2]), 1);
      irqV[2] = 1'b0;
      tick(10);
      compareInt("line2 pending after drop", int'(INT_OUT[2]), 1);
      ackV[2] = 1'b1;
      tick(5);
      compareInt("line2 cleared", int'(INT_OUT[2]), 0);

      // Line 1: 3-cycle pulse filtered out, 4-cycle pulse gets through
      irqV[1] = 1'b1;
      tick(3);
      irqV[1] = 1'b0;
      tick(12);
      compareInt("line1 short pulse", int'(INT_OUT[1]), 0);
      irqV[1] = 1'b1;
      tick(4);
      irqV[1] = 1'b0;
      tick(12);
      compareInt("line1 full pulse", int'(INT_OUT[1]), 1);
      ackV[1] = 1'b1;
      tick(1);

      // Line 3 edge mode: overrun, edge coincident with ACK, clear
      irqV[3] = 1'b1; tick(8);
      irqV[3] = 1'b0; tick(8);
      irqV[3] = 1'b1; tick(8);
      compareInt("line3 overrun", int'(OVERRUN[3]), 1);
      irqV[3] = 1'b0; tick(8);
      irqV[3] = 1'b1; tick(SS + FC);
      ackV[3] = 1'b1;
      tick(1);
      compareInt("line3 edge beats ACK", int'(INT_OUT[3]), 1);
      compareInt("line3 overrun unchanged", int'(OVERRUN[3]), 1);
      clrV[3] = 1'b1;
      tick(1);
      compareInt("line3 overrun cleared", int'(OVERRUN[3]), 0);
      irqV = '0;
      tick(10);

      // Mid-filter asynchronous reset with a line pending
      emV = '0;
      irqV[4] = 1'b1;
      tick(10);
      irqV[5] = 1'b1;
      tick(3);
      doReset();
      measureLatency("post-reset latency line4", 4, SS + FC + 1);
      irqV = '0;
      tick(10);
      ackV = 7'b0110000;
      tick(10);

      // Randomised traffic against the reference model
      for (int seg = 0; seg < 6; seg++) begin
         emV = N'($urandom);
         for (int c = 0; c < 120; c++) begin
            for (int i = 0; i < N; i++) begin
               flip[i] = ($urandom_range(0, 7) == 0);
               if ($urandom_range(0, 59) == 0) enV[i] = ~enV[i];
            end
            irqV = irqV ^ flip;
            if ($urandom_range(0, 3) == 0) ackV = N'(1) << $urandom_range(0, N - 1);
            if ($urandom_range(0, 9) == 0) clrV = N'($urandom);
            tick(1);
         end
      end

      // Let the monitor drain, bounded
      drainWait = 0;
      while (scoreQ.size() > 0 && drainWait < 5) begin
         @(negedge CLK);
         #1;
         drainWait++;
      end
      compareInt("scoreboard drained", scoreQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule : tb_int_request_conditioner

// File: doc/int_request_conditioner.md
# int_request_conditioner

Conditions the raw external interrupt lines before they reach the coprocessor-0 interrupt inputs (INT1..INT7). Each line is synchronised into the CPU clock domain, glitch-filtered, converted to a level or edge request per its mode, and held pending until coprocessor 0 acknowledges entry for that line. The block sits directly upstream of CP0 in the top level. Its outputs drive CP0's INT1..INT7, and its acknowledge inputs come from CP0's taken-interrupt one-hot, qualified by pipeline-ready.

## Interface
Parameters:
- NUM_LINES, 7: external interrupt lines; bit i drives CP0 INT(i+1).
- SYNC_STAGES, 2: synchroniser depth. Minimum 2.
- FILTER_CYCLES, 4: consecutive stable cycles required before the filtered level changes. Minimum 1.

Ports:
- CLK  in  1  sole clock; all state on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IRQ_IN  in  NUM_LINES  raw asynchronous interrupt lines.
- ENABLE  in  NUM_LINES  per-line enable, quasi-static.
- EDGE_MODE  in  NUM_LINES  1 = rising-edge triggered, 0 = level triggered.
- ACK  in  NUM_LINES  one-hot acknowledge from CP0 (taken line AND pipeline-ready); valid for one cycle.
- OVR_CLR  in  NUM_LINES  clears the matching OVERRUN bits.
- INT_OUT  out  NUM_LINES  registered pending requests to CP0 INT1..INT7.
- OVERRUN  out  NUM_LINES  sticky flag: edge arrived while the line was already pending.
- FILTERED  out  NUM_LINES  debounced line levels, for status reads.

## Operation
- Reset: all synchroniser flops, filter counters, FILTERED, INT_OUT and OVERRUN are cleared to 0. Reset is asynchronous, can assert mid-filter, and discards all in-flight requests.
- Synchroniser:
  - s[i] is IRQ_IN[i] after SYNC_STAGES flops.
- Filter, per line; counter width clog2(FILTER_CYCLES+1):
  - If s == FILTERED, cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1, FILTERED <= s and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any single-cycle mismatch back to FILTERED restarts the count.
  - The filter runs regardless of ENABLE.
- Edge detect: rise[i] = FILTERED[i] & ~FILTERED_q[i], where FILTERED_q is a one-cycle delayed copy, also reset to 0.
- Set condition: set = ENABLE & (EDGE_MODE ? rise : FILTERED).
- Pending update, in priority order:
  1. ENABLE=0: INT_OUT <= 0.
  2. set: INT_OUT <= 1. Set wins over a simultaneous ACK, so no edge is lost.
  3. ACK: INT_OUT <= 0.
  4. Otherwise INT_OUT holds.
- Level mode: after ACK, a still-high line re-asserts INT_OUT on the next cycle. The ACK cycle itself sets again, so INT_OUT stays 1.
- Overrun: set when EDGE_MODE & ENABLE & rise & INT_OUT & ~ACK. OVR_CLR clears it; a simultaneous set wins over OVR_CLR.
- Lines are fully independent. No arbitration is done here; CP0 prioritises.

## Timing
- Assert latency: IRQ_IN rises and is stable before edge 1:
  - s high after edge SYNC_STAGES.
  - FILTERED high after edge SYNC_STAGES+FILTER_CYCLES.
  - INT_OUT high after edge SYNC_STAGES+FILTER_CYCLES+1. Defaults: 7 edges.
- Deassert latency is the same for FILTERED. In level mode INT_OUT stays 1 until ACK, even after the line drops.
- ACK at edge n: INT_OUT = 0 after edge n, unless set is active that cycle.
- ENABLE falling clears INT_OUT on the next edge. Rising ENABLE while level-mode FILTERED=1 sets INT_OUT on the next edge.
- A pulse shorter than FILTER_CYCLES cycles at the synchroniser output never reaches FILTERED.

## Structure
- Sub-module int_line_filter: synchroniser, filter counter and FILTERED/FILTERED_q registers for one line. Instantiated NUM_LINES times in a generate loop.
- Top level holds the pending, overrun and set/ACK logic.
- The shared defines header gains CP0_NUM_EXT_INT (7) and INT_FILTER_CYCLES_DEFAULT (4). CP0 and this block use the same line count.

## Test plan
- Reset release, IRQ_IN=0, ENABLE=all-ones → INT_OUT=0, OVERRUN=0, FILTERED=0 for 20 cycles.
- Line 0, edge mode, IRQ_IN[0] rising and held → INT_OUT[0]=1 exactly 7 edges later. ACK[0] pulse → 0 next edge, and stays 0 while the line remains high.
- Line 2, level mode, line held high, ACK[2] pulse → INT_OUT[2] remains 1. Line dropped, then ACK → INT_OUT[2]=0 and stays 0.
- Line 1: 3-cycle high pulse → no INT_OUT. 4-cycle pulse → INT_OUT[1]=1.
- Line 3, edge mode: second rising edge while pending → OVERRUN[3]=1. Edge coincident with ACK[3] → INT_OUT[3]=1 and OVERRUN unchanged. OVR_CLR[3] → OVERRUN[3]=0.
- RESET asserted asynchronously mid-filter, with lines pending → all outputs 0 immediately. After release, a still-high line needs a full 7-edge latency again.
